// File: rtl/st7920_pkg.sv
// Shared definitions for the ST7920 serial LCD driver: command bytes,
// the power-on init sequence, serial frame packing and state enums.
package st7920_pkg;

  localparam logic [7:0] FUNC_BASIC   = 8'h30;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] ENTRY        = 8'h06;
  localparam logic [7:0] FUNC_EXT     = 8'h34;
  localparam logic [7:0] FUNC_EXT_GFX = 8'h36;

  localparam int INIT_LEN   = 6;
  localparam int FRAME_BITS = 24;

  localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{
    FUNC_BASIC, DISP_ON, CLEAR, ENTRY, FUNC_EXT, FUNC_EXT_GFX
  };

  typedef enum logic [2:0] {
    SEQ_POWERUP,
    SEQ_INIT,
    SEQ_VADDR,
    SEQ_HADDR,
    SEQ_DATA
  } seq_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_state_t;

  // Sync byte 11111_RW_RS_0 (RW always write), then the byte split into
  // two nibbles, each left-aligned in its own byte.
  function automatic logic [23:0] build_frame(input logic rs, input logic [7:0] data);
    return {5'b11111, 1'b0, rs, 1'b0, data[7:4], 4'b0000, data[3:0], 4'b0000};
  endfunction

endpackage

// File: rtl/st7920_serial_tx.sv
// Shifts one 24-bit ST7920 serial frame out MSB first on SCLK/SID and then
// holds the lines low for the inter-frame gap the LCD needs to execute it.
module st7920_serial_tx
  import st7920_pkg::*;
#(
  parameter int CLK_DIV_BITS = 4,
  parameter int DELAY_BITS   = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n_ms,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] tx_byte,
  input  logic       long_gap,
  output logic       busy,
  output logic       lcd_clk,
  output logic       lcd_data
);

  localparam int GAP_W = DELAY_BITS + CLK_DIV_BITS + 4;
  localparam logic [GAP_W-1:0] GAP_SHORT_LAST =
    GAP_W'((64'd1 << (DELAY_BITS + CLK_DIV_BITS)) - 64'd1);
  localparam logic [GAP_W-1:0] GAP_LONG_LAST = {GAP_W{1'b1}};
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  tx_state_t               state;
  logic [23:0]             shreg;
  logic [23:0]             load_frame;
  logic [4:0]              bit_cnt;
  logic [CLK_DIV_BITS-1:0] div_cnt;
  logic [CLK_DIV_BITS-1:0] div_next;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    long_q;

  assign load_frame = build_frame(rs, tx_byte);
  assign div_next   = div_cnt + 1'b1;
  assign busy       = (state != TX_IDLE);

  // Frame shifter: SCLK is the top bit of the divider so each bit is low for
  // its first half and high for its second; SID only moves at bit starts.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n_ms) begin
      state    <= TX_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      long_q   <= 1'b0;
      lcd_clk  <= 1'b0;
      lcd_data <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            state    <= TX_SHIFT;
            shreg    <= {load_frame[22:0], 1'b0};
            lcd_data <= load_frame[23];
            lcd_clk  <= 1'b0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            long_q   <= long_gap;
          end
        end
        TX_SHIFT: begin
          if (div_cnt == {CLK_DIV_BITS{1'b1}}) begin
            div_cnt <= '0;
            lcd_clk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state    <= TX_GAP;
              lcd_data <= 1'b0;
              gap_cnt  <= '0;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              lcd_data <= shreg[23];
              shreg    <= {shreg[22:0], 1'b0};
            end
          end else begin
            div_cnt <= div_next;
            lcd_clk <= div_next[CLK_DIV_BITS-1];
          end
        end
        TX_GAP: begin
          if (gap_cnt == (long_q ? GAP_LONG_LAST : GAP_SHORT_LAST)) begin
            state <= TX_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/st7920_serial_driver.sv
// Keeps a 128x64 ST7920 LCD refreshed from the parent's 1 KiB frame buffer:
// power-up wait, one-time init, then endless GDRAM row streaming.
module st7920_serial_driver
  import st7920_pkg::*;
#(
  parameter int CLK_DIV_BITS   = 4,
  parameter int DELAY_BITS     = 8,
  parameter int POWERUP_CYCLES = 1_080_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n_ms,
  input  logic [7:0] memory [0:1023],
  output logic       lcd_clk,
  output logic       lcd_data,
  output logic [5:0] led
);

  localparam int PU_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam logic [PU_W-1:0] PU_LAST = PU_W'(POWERUP_CYCLES - 1);
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  seq_state_t      seq_state;
  logic [PU_W-1:0] pu_cnt;
  logic [2:0]      init_idx;
  logic [4:0]      row;
  logic [4:0]      col;
  logic [5:0]      frame_count;

  logic            tx_start;
  logic            tx_rs;
  logic [7:0]      tx_byte;
  logic            tx_long;
  logic            tx_busy;

  assign tx_start = (seq_state != SEQ_POWERUP) && !tx_busy;

  // Next frame to send; the GDRAM byte is read live so the shifter captures
  // whatever the buffer holds on the load cycle. Column bit 4 selects the
  // lower screen half, which lives 32 rows further down the buffer.
  always_comb begin
    tx_rs   = 1'b0;
    tx_byte = 8'h00;
    tx_long = 1'b0;
    case (seq_state)
      SEQ_INIT: begin
        tx_byte = INIT_ROM[init_idx];
        tx_long = (INIT_ROM[init_idx] == CLEAR);
      end
      SEQ_VADDR: tx_byte = {3'b100, row};
      SEQ_HADDR: tx_byte = 8'h80;
      SEQ_DATA: begin
        tx_rs   = 1'b1;
        tx_byte = memory[{col[4], row, col[3:0]}];
      end
      default: ;
    endcase
  end

  // Sequencer: advances to the following frame each time the shifter accepts one.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n_ms) begin
      seq_state   <= SEQ_POWERUP;
      pu_cnt      <= '0;
      init_idx    <= '0;
      row         <= '0;
      col         <= '0;
      frame_count <= '0;
      led         <= 6'b111111;
    end else begin
      case (seq_state)
        SEQ_POWERUP: begin
          if (pu_cnt == PU_LAST) begin
            seq_state <= SEQ_INIT;
          end else begin
            pu_cnt <= pu_cnt + 1'b1;
          end
        end
        SEQ_INIT: begin
          if (tx_start) begin
            if (init_idx == INIT_LAST) begin
              init_idx  <= '0;
              row       <= '0;
              seq_state <= SEQ_VADDR;
            end else begin
              init_idx <= init_idx + 1'b1;
            end
          end
        end
        SEQ_VADDR: begin
          if (tx_start) seq_state <= SEQ_HADDR;
        end
        SEQ_HADDR: begin
          if (tx_start) begin
            col       <= '0;
            seq_state <= SEQ_DATA;
          end
        end
        SEQ_DATA: begin
          if (tx_start) begin
            if (col == 5'd31) begin
              col       <= '0;
              row       <= row + 1'b1;
              seq_state <= SEQ_VADDR;
              if (row == 5'd31) begin
                frame_count <= frame_count + 1'b1;
                led         <= ~(frame_count + 6'd1);
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: seq_state <= SEQ_POWERUP;
      endcase
    end
  end

  st7920_serial_tx #(
    .CLK_DIV_BITS(CLK_DIV_BITS),
    .DELAY_BITS  (DELAY_BITS)
  ) u_tx (
    .sys_clk     (sys_clk),
    .sys_rst_n_ms(sys_rst_n_ms),
    .start       (tx_start),
    .rs          (tx_rs),
    .tx_byte     (tx_byte),
    .long_gap    (tx_long),
    .busy        (tx_busy),
    .lcd_clk     (lcd_clk),
    .lcd_data    (lcd_data)
  );

endmodule

// File: tb/tb_st7920_serial_driver.sv
// Bench for st7920_serial_driver: decodes SID on SCLK rising edges and
// compares every frame with a model of the command/data stream.
module tb_st7920_serial_driver;

  localparam int CDB         = 1;
  localparam int DB          = 2;
  localparam int PU          = 10;
  localparam int T           = 1 << CDB;
  localparam int GAP         = (1 << DB) * T;
  localparam int FRAME_CYC   = 24 * T;
  localparam int PASS_FRAMES = 32 * 34;
  localparam int WAIT_BUDGET = 600;

  typedef struct {
    logic [23:0] f;
    int          start;
  } rx_t;

  logic       sys_clk;
  logic       sys_rst_n_ms;
  logic [7:0] mem [0:1023];
  logic       lcd_clk;
  logic       lcd_data;
  logic [5:0] led;

  logic [7:0] init_tbl [0:5] = '{8'h30, 8'h0C, 8'h01, 8'h06, 8'h34, 8'h36};

  int         checks   = 0;
  int         failures = 0;
  int         next_n   = 0;
  bit         dead     = 0;

  rx_t        rx_q [$];
  int         cyc      = 0;
  logic       prev_clk = 1'b0;
  int         nbits    = 0;
  logic [23:0] shacc   = '0;
  int         fstart   = 0;

  st7920_serial_driver #(
    .CLK_DIV_BITS  (CDB),
    .DELAY_BITS    (DB),
    .POWERUP_CYCLES(PU)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n_ms(sys_rst_n_ms),
    .memory      (mem),
    .lcd_clk     (lcd_clk),
    .lcd_data    (lcd_data),
    .led         (led)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Serial receiver model: collect SID on each SCLK rising edge into frames.
  always @(negedge sys_clk) begin
    cyc      <= cyc + 1;
    prev_clk <= lcd_clk;
    if (!sys_rst_n_ms) begin
      nbits <= 0;
    end else if (lcd_clk === 1'b1 && prev_clk === 1'b0) begin
      shacc <= {shacc[22:0], lcd_data};
      if (nbits == 0) fstart <= cyc;
      if (nbits == 23) begin
        rx_q.push_back('{f: {shacc[22:0], lcd_data}, start: fstart});
        nbits <= 0;
      end else begin
        nbits <= nbits + 1;
      end
    end
  end

  // Frame n after reset: 6 init commands, then per row a vertical address,
  // a horizontal address and 32 data bytes (16 from the upper half, 16 from
  // the lower half 32 rows later), repeating every 32 rows.
  function automatic logic [23:0] exp_frame(input int n);
    int m, r, j, k, addr;
    logic [7:0] b;
    logic [7:0] sync;
    sync = 8'hF8;
    b    = 8'h00;
    if (n < 6) begin
      b = init_tbl[n];
    end else begin
      m = (n - 6) % PASS_FRAMES;
      r = m / 34;
      j = m % 34;
      if (j == 0) begin
        b = 8'(8'h80 + r);
      end else if (j == 1) begin
        b = 8'h80;
      end else begin
        sync = 8'hFA;
        k    = j - 2;
        addr = (k < 16) ? (r * 16 + k) : ((r + 32) * 16 + (k - 16));
        b    = mem[addr];
      end
    end
    return {sync, b[7:4], 4'h0, b[3:0], 4'h0};
  endfunction

  function automatic int gap_after(input int n);
    return (n == 2) ? 16 * GAP : GAP;
  endfunction

  task automatic wait_frame(output rx_t fr, output bit ok);
    ok       = 1'b0;
    fr.f     = 'x;
    fr.start = 0;
    if (dead) return;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      if (rx_q.size() > 0) begin
        fr = rx_q.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge sys_clk);
    end
    dead = 1'b1;
    $display("[TB] no frame decoded within %0d cycles", WAIT_BUDGET);
  endtask

  task automatic test_reset();
    int  first;
    int  early;
    bit  data_bad;
    sys_rst_n_ms = 1'b0;
    repeat (5) @(negedge sys_clk);
    checks++;
    if (lcd_clk !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_lcd_clk got=%b want=0", lcd_clk);
    end
    checks++;
    if (lcd_data !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_lcd_data got=%b want=0", lcd_data);
    end
    checks++;
    if (led !== 6'b111111) begin
      failures++;
      $display("[TB] FAIL reset_led got=%b want=111111", led);
    end
    sys_rst_n_ms = 1'b1;
    first    = 0;
    early    = 0;
    data_bad = 1'b0;
    for (int i = 1; i <= 200 && first == 0; i++) begin
      @(negedge sys_clk);
      if (lcd_clk === 1'b1) begin
        first = i;
        if (i <= 10) early++;
      end else if (lcd_data !== 1'b0 && i <= PU) begin
        data_bad = 1'b1;
      end
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("[TB] FAIL powerup_quiet sclk_high_at=%0d want_after=10", first);
    end
    checks++;
    if (data_bad) begin
      failures++;
      $display("[TB] FAIL powerup_sid got=nonzero want=0");
    end
    checks++;
    if (first != PU + 1 + T / 2) begin
      failures++;
      $display("[TB] FAIL first_sclk_rise got=%0d want=%0d", first, PU + 1 + T / 2);
    end
  endtask

  task automatic test_init();
    rx_t fr;
    bit  ok;
    int  prev_start;
    prev_start = 0;
    for (int j = 0; j < 6; j++) begin
      wait_frame(fr, ok);
      checks++;
      if (!ok || fr.f !== exp_frame(next_n)) begin
        failures++;
        $display("[TB] FAIL init_frame%0d got=%h want=%h", j, fr.f, exp_frame(next_n));
      end
      if (j > 0) begin
        checks++;
        if (!ok || fr.start - prev_start != FRAME_CYC + gap_after(next_n - 1) + 1) begin
          failures++;
          $display("[TB] FAIL init_spacing%0d got=%0d want=%0d", j, fr.start - prev_start,
                   FRAME_CYC + gap_after(next_n - 1) + 1);
        end
      end
      prev_start = fr.start;
      next_n++;
    end
  endtask

  task automatic test_data_mapping();
    rx_t fr;
    bit  ok;
    for (int j = 0; j < 68; j++) begin
      wait_frame(fr, ok);
      checks++;
      if (!ok || fr.f !== exp_frame(next_n)) begin
        failures++;
        $display("[TB] FAIL map_frame%0d got=%h want=%h", next_n, fr.f, exp_frame(next_n));
      end
      next_n++;
    end
  endtask

  task automatic test_live_update();
    rx_t        fr;
    bit         ok;
    int         r, k, addr, target;
    logic [7:0] newv;
    mem[0] = 8'hFF;
    r      = $urandom_range(8, 31);
    k      = $urandom_range(0, 31);
    addr   = (k < 16) ? (r * 16 + k) : ((r + 32) * 16 + (k - 16));
    newv   = ~mem[addr];
    mem[addr] = newv;
    target = 6 + r * 34 + 2 + k;
    while (next_n < 6 + PASS_FRAMES - 1) begin
      wait_frame(fr, ok);
      checks++;
      if (!ok || fr.f !== exp_frame(next_n)) begin
        failures++;
        $display("[TB] FAIL pass1_frame%0d got=%h want=%h", next_n, fr.f, exp_frame(next_n));
      end
      if (next_n == target) begin
        checks++;
        if (fr.f !== {8'hFA, newv[7:4], 4'h0, newv[3:0], 4'h0}) begin
          failures++;
          $display("[TB] FAIL live_byte got=%h want=%h", fr.f,
                   {8'hFA, newv[7:4], 4'h0, newv[3:0], 4'h0});
        end
      end
      next_n++;
    end
  endtask

  task automatic test_wrap_led();
    rx_t fr;
    bit  ok;
    checks++;
    if (led !== 6'b111111) begin
      failures++;
      $display("[TB] FAIL led_before_wrap got=%b want=111111", led);
    end
    wait_frame(fr, ok);
    checks++;
    if (!ok || fr.f !== exp_frame(next_n)) begin
      failures++;
      $display("[TB] FAIL last_frame got=%h want=%h", fr.f, exp_frame(next_n));
    end
    next_n++;
    checks++;
    if (led !== 6'b111110) begin
      failures++;
      $display("[TB] FAIL led_after_wrap got=%b want=111110", led);
    end
    wait_frame(fr, ok);
    checks++;
    if (!ok || fr.f !== 24'hF8_80_00) begin
      failures++;
      $display("[TB] FAIL wrap_vaddr got=%h want=f88000", fr.f);
    end
    next_n++;
    wait_frame(fr, ok);
    checks++;
    if (!ok || fr.f !== exp_frame(next_n)) begin
      failures++;
      $display("[TB] FAIL wrap_haddr got=%h want=%h", fr.f, exp_frame(next_n));
    end
    next_n++;
    wait_frame(fr, ok);
    checks++;
    if (!ok || fr.f !== 24'hFA_F0_F0) begin
      failures++;
      $display("[TB] FAIL pass2_byte0 got=%h want=faf0f0", fr.f);
    end
    next_n++;
  endtask

  task automatic test_mid_frame_reset();
    rx_t fr;
    bit  ok;
    bit  found;
    int  first;
    found = 1'b0;
    for (int i = 0; i < WAIT_BUDGET && !found; i++) begin
      @(negedge sys_clk);
      if (nbits >= 10 && lcd_clk === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL midreset_reach got=none want=bit10");
    end
    sys_rst_n_ms = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (lcd_clk !== 1'b0 || lcd_data !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_lines got=%b%b want=00", lcd_clk, lcd_data);
    end
    checks++;
    if (led !== 6'b111111) begin
      failures++;
      $display("[TB] FAIL midreset_led got=%b want=111111", led);
    end
    repeat (3) @(negedge sys_clk);
    rx_q.delete();
    next_n = 0;
    sys_rst_n_ms = 1'b1;
    first = 0;
    for (int i = 1; i <= 200 && first == 0; i++) begin
      @(negedge sys_clk);
      if (lcd_clk === 1'b1) first = i;
    end
    checks++;
    if (first != PU + 1 + T / 2) begin
      failures++;
      $display("[TB] FAIL midreset_powerup got=%0d want=%0d", first, PU + 1 + T / 2);
    end
    wait_frame(fr, ok);
    checks++;
    if (!ok || fr.f !== exp_frame(0)) begin
      failures++;
      $display("[TB] FAIL midreset_init got=%h want=%h", fr.f, exp_frame(0));
    end
  endtask

  initial begin
    sys_rst_n_ms = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    $display("[TB] starting");
    test_reset();
    test_init();
    test_data_mapping();
    test_live_update();
    test_wrap_led();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/st7920_serial_driver.md
# st7920_serial_driver

Continuously refreshes a 128x64 ST7920 graphic LCD over its 2-wire serial interface (SCLK on E, SID on R/W; CS tied high on the board) from a 1024-byte frame buffer owned by the parent. After power-up it waits, sends a fixed 6-command init sequence, then streams the whole buffer into GDRAM forever. The parent may modify the buffer at any time, and changes appear on the next pass. It sits between the top-level frame-buffer logic and the LCD pins, and also drives six status LEDs.

## Interface
Parameters:
- CLK_DIV_BITS, 4: each serial bit lasts 2^CLK_DIV_BITS sys_clk cycles (16 by default).
- DELAY_BITS, 8: the gap after each 24-bit frame lasts 2^DELAY_BITS bit periods.
- POWERUP_CYCLES, 1_080_000: sys_clk cycles idled after reset before the first frame (40 ms at 27 MHz).

Ports (one clock; reset is synchronous and active-low):
- sys_clk, input, 1: system clock.
- sys_rst_n_ms, input, 1: synchronous active-low reset.
- memory, input, 8 x [0:1023]: frame buffer. Row-major, 64 rows x 16 bytes, MSB = leftmost pixel.
- lcd_clk, output, 1: serial clock (SCLK/E).
- lcd_data, output, 1: serial data (SID/RW).
- led, output, 6: active-low status, equal to ~frame_count[5:0].

## Operation
- **Frame format:** 24 bits, MSB first.
  - Sync byte 11111_RW_RS_0, with RW=0. RS=0 for commands and RS=1 for GDRAM data.
  - Then {d[7:4],4'b0000}.
  - Then {d[3:0],4'b0000}.
- **Init sequence**, in order: 0x30, 0x0C, 0x01, 0x06, 0x34, 0x36. After this, extended instruction set and graphics display are on.
- **Refresh loop:** row r = 0..31.
  - Command 0x80|r (vertical address).
  - Command 0x80 (horizontal address 0).
  - 32 data bytes, relying on the LCD's auto-increment.
  - Byte k (0..31) of row r reads memory[r*16+k] for k<16, and memory[(r+32)*16+(k-16)] for k>=16. This maps the LCD's upper and lower halves.
- After row 31, frame_count increments (6+ bits, wraps) and the loop restarts at row 0. Init is never resent.
- **Data capture:** each data byte is sampled from memory at frame load time, not before.
- **Sequencer states:** POWERUP → INIT(idx 0..5) → VADDR → HADDR → DATA(k 0..31) → next row or wrap to VADDR at r=0.
- **Shifter states:** IDLE → SHIFT (24 bits) → GAP → IDLE. The sequencer loads the next frame only when the shifter is IDLE.
- Reset mid-operation abandons any frame immediately: outputs go to reset values and the sequence restarts at POWERUP.

## Timing
- **Reset values:** lcd_clk=0, lcd_data=0, led=6'b111111, frame_count=0, all counters 0.
- **POWERUP:** POWERUP_CYCLES cycles with lcd_clk=0 and lcd_data=0.
- **Bit period:** T = 2^CLK_DIV_BITS cycles.
  - lcd_data changes only at the start of a bit.
  - lcd_clk is low for the first T/2 cycles and high for the second T/2. The LCD samples on the rising edge.
- **Gap:** 2^DELAY_BITS x T cycles with lcd_clk=0 and lcd_data=0. After 0x01 (clear) the gap is 16x longer.
- **Frame cost:** 24T + gap. With defaults this is 384 + 4096 = 4480 cycles.
- **Load latency:** first bit of the next frame starts on the cycle after the gap ends. This means exactly one IDLE/load cycle between frames.
- **Full refresh:** 32 x 34 frames.
- **led** updates on the cycle frame_count increments.

## Structure
- **Package st7920_pkg:**
  - Command constants (FUNC_BASIC=0x30, DISP_ON=0x0C, CLEAR=0x01, ENTRY=0x06, FUNC_EXT=0x34, FUNC_EXT_GFX=0x36).
  - Init ROM array.
  - Function building the 24-bit frame from {rs, byte}.
  - State enums.
- **Sub-module st7920_serial_tx:** frame shifter with ports start, rs, byte, long_gap, busy, lcd_clk, lcd_data; it owns bit and gap timing.
- **Top:** sequencer plus address mapping.

## Test plan
Use CLK_DIV_BITS=1, DELAY_BITS=2, POWERUP_CYCLES=10 unless noted.

- **Reset:** hold reset low for 5 cycles → lcd_clk=0, lcd_data=0, led=111111. Release → no lcd_clk rising edge for 10 cycles.
- **Init capture:** decode SID on SCLK rising edges → frames 0xF8,0x30,0x00 / 0xF8,0x00,0xC0 / 0xF8,0x00,0x10 / 0xF8,0x00,0x60 / 0xF8,0x30,0x40 / 0xF8,0x30,0x60. Gap after 0x01 is 128 cycles; others are 8.
- **Data mapping:** memory[i]=i[7:0] → row 0 sends 0xF8 0x80 0x00, 0xF8 0x80 0x00, then data frames (sync 0xFA) carrying 0x00..0x0F followed by 0x00..0x0F of memory[512..527] (=0x00..0x0F). Row 1 begins with vertical address 0x81.
- **Wrap / LED:** run one full refresh → frame_count=1, led=111110. Next frame is 0x80|0 vertical address with no init resent.
- **Live update:** set memory[0]=0xFF after the pass-1 row-0 load → pass 2 first data byte = 0xFF.
- **Mid-frame reset:** assert reset during bit 10 of a data frame → outputs zero next cycle. After release, the powerup wait and init 0x30 repeat.
